lsu_dmem: RTL and testbench

//  Load/store unit plus 32-bit data memory, downstream of the ALU in the monocycle core.

---
 rtl/lsu_dmem.sv | 126 ++++++++++++
 tb/tb_lsu_dmem.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// Load/store unit with a private word-organised data memory.
// Loads take accept->READ->RESP; stores and rejected ops go straight to RESP.
module lsu_dmem #(
  parameter int ADDR_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx, idx_q;
  logic [1:0]       lane_q;
  logic [2:0]       funct3_q;
  logic             bad;
  logic [3:0]       be;
  logic [31:0]      wlane;
  logic             unused_addr;

  // Upper address bits alias onto the same words by design.
  assign unused_addr = ^addr_i[31:ADDR_W];
  assign idx         = addr_i[ADDR_W-1:2];
  assign busy_o      = rst_ni && ((state == IDLE && req_i) || state == READ);

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    bad   = 1'b0;
    be    = 4'b0000;
    wlane = wdata_i;
    if (we_i) bad = (funct3_i[2] || funct3_i[1:0] == 2'b11);
    else      bad = (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11);
    if (funct3_i[1:0] == 2'b01 && addr_i[0])          bad = 1'b1;
    if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) bad = 1'b1;
    case (funct3_i[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_i[1:0];
        wlane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // NOTE: the RAM array has no reset; contents survive rst_ni, only the write is gated by it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state == IDLE && req_i && we_i && !bad) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= IDLE;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          if (req_i) begin
            idx_q    <= idx;
            lane_q   <= addr_i[1:0];
            funct3_q <= funct3_i;
            if (bad || we_i) begin
              state   <= RESP;
              done_o  <= 1'b1;
              err_o   <= bad;
              rdata_o <= '0;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          rdata_o <= fmt_load(mem[idx_q], funct3_q, lane_q);
          done_o  <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          done_o <= 1'b0;
          err_o  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: latency, lane formatting, errors, aliasing and resets.
module tb_lsu_dmem;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int n_pass = 0;
  int n_total = 0;

  lsu_dmem #(.ADDR_W(8)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .funct3_i(funct3_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issues one op starting at the next falling edge; returns when done_o is seen or the bound expires.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    bit seen;
    @(negedge clk_i);
    req_i    = 1'b1;
    we_i     = we;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wdata;
    #1 check({tag, ".busy_accept"}, 32'(busy_o), 32'd1);
    @(posedge clk_i);
    #1 req_i = 1'b0;
    seen = 1'b0;
    for (lat = 1; lat < 6; lat++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".err"}, 32'(err_o), 32'(exp_err));
      check({tag, ".busy_resp"}, 32'(busy_o), 32'd0);
      if (!we || exp_err) check({tag, ".rdata"}, rdata_o, exp_rdata);
    end
  endtask

  initial begin
    rst_ni   = 1'b0;
    req_i    = 1'b0;
    we_i     = 1'b0;
    funct3_i = 3'b000;
    addr_i   = '0;
    wdata_i  = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    run_op("seed0", 1'b1, 3'b010, 32'h00, 32'h0000_0000, 32'h0, 1'b0, 1);

    // T1: reset held with a store request pending must not write or respond
    @(negedge clk_i);
    rst_ni   = 1'b0;
    req_i    = 1'b1;
    we_i     = 1'b1;
    funct3_i = 3'b010;
    addr_i   = 32'h00;
    wdata_i  = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t1.busy", 32'(busy_o), 32'd0);
      check("t1.done", 32'(done_o), 32'd0);
      check("t1.rdata", rdata_o, 32'h0);
    end
    req_i  = 1'b0;
    rst_ni = 1'b1;
    run_op("t1.lw0", 1'b0, 3'b010, 32'h00, 32'h0, 32'h0000_0000, 1'b0, 2);

    // T2
    run_op("t2.sw",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    run_op("t2.lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

    // T3
    run_op("t3.lb13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 2);
    run_op("t3.lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 2);
    run_op("t3.lh12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 2);
    run_op("t3.lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, 2);
    run_op("t3.lb10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 2);
    run_op("t3.lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 2);

    // T4
    run_op("t4.sb11", 1'b1, 3'b000, 32'h11, 32'h1234_5655, 32'h0, 1'b0, 1);
    run_op("t4.lw_a", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 2);
    run_op("t4.sh12", 1'b1, 3'b001, 32'h12, 32'h0000_A5A5, 32'h0, 1'b0, 1);
    run_op("t4.lw_b", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 2);

    // T5: rejected ops respond after one cycle and leave memory alone
    run_op("t5.lw12",   1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1);
    run_op("t5.sh13",   1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    run_op("t5.ld011",  1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    run_op("t5.sb100",  1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    run_op("t5.lw_chk", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 2);

    // T6: upper address bits alias
    run_op("t6.sw104", 1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    run_op("t6.lw04",  1'b0, 3'b010, 32'h04, 32'h0, 32'hCAFE_F00D, 1'b0, 2);

    // T6: reset during READ discards the load without a done pulse
    @(negedge clk_i);
    req_i    = 1'b1;
    we_i     = 1'b0;
    funct3_i = 3'b010;
    addr_i   = 32'h04;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(negedge clk_i);
    check("t6.busy_read", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    #1 check("t6.busy_rst", 32'(busy_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("t6.done_rst", 32'(done_o), 32'd0);
      check("t6.rdata_rst", rdata_o, 32'h0);
    end
    rst_ni = 1'b1;
    run_op("t6.after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 2);

    // done_o and err_o stay low once the response has retired
    @(negedge clk_i);
    check("idle.done", 32'(done_o), 32'd0);
    check("idle.err", 32'(err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
